// File: rtl/reg_bus_arbiter.sv
// Arbitrates the 12-bit peripheral register bus between the lisp core (absolute priority)
// and one auxiliary requester using a req/ack handshake with a starvation timeout.
module reg_bus_arbiter #(
  parameter logic [15:0] AUX_TIMEOUT = 16'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cpu_index,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_write_value,
  output logic [15:0] cpu_read_value,
  input  logic        aux_req,
  input  logic        aux_write,
  input  logic [11:0] aux_index,
  input  logic [15:0] aux_write_value,
  output logic        aux_ack,
  output logic        aux_error,
  output logic [15:0] aux_read_value,
  output logic [11:0] register_index,
  output logic        register_read,
  output logic        register_write,
  output logic [15:0] register_write_value,
  input  logic [15:0] register_read_value
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_next;
  logic [15:0] wait_cnt, wait_cnt_next;
  logic        err_q, err_next;
  logic        rd_q, rd_next;
  logic        last_cpu_read;
  logic [15:0] read_hold;
  logic        cpu_cycle, aux_issue, aux_timeout, resp_live;

  always_comb begin
    cpu_cycle   = cpu_read | cpu_write;
    aux_issue   = !cpu_cycle && (state == IDLE) && aux_req;
    aux_timeout = cpu_cycle && (state == IDLE) && aux_req
                  && (wait_cnt == AUX_TIMEOUT - 16'd1);
  end

  // Bus drive: the core always wins; aux only gets an idle cycle while in IDLE.
  always_comb begin
    register_index       = '0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_write_value = '0;
    if (cpu_cycle) begin
      register_index       = cpu_index;
      register_write       = cpu_write;
      register_read        = cpu_read & !cpu_write;
      register_write_value = cpu_write_value;
    end else if (aux_issue) begin
      register_index       = aux_index;
      register_write       = aux_write;
      register_read        = !aux_write;
      register_write_value = aux_write_value;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_next      = err_q;
    rd_next       = rd_q;
    case (state)
      IDLE: begin
        if (aux_issue) begin
          state_next    = RESP;
          wait_cnt_next = '0;
          err_next      = 1'b0;
          rd_next       = !aux_write;
        end else if (aux_timeout) begin
          state_next    = RESP;
          wait_cnt_next = '0;
          err_next      = 1'b1;
          rd_next       = 1'b0;
        end else if (aux_req) begin
          wait_cnt_next = wait_cnt + 16'd1;
        end else begin
          wait_cnt_next = '0;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      err_q         <= 1'b0;
      rd_q          <= 1'b0;
      read_hold     <= '0;
      last_cpu_read <= 1'b0;
    end else begin
      state         <= state_next;
      wait_cnt      <= wait_cnt_next;
      err_q         <= err_next;
      rd_q          <= rd_next;
      last_cpu_read <= cpu_read & !cpu_write;
      if (state == RESP)
        read_hold <= rd_q ? register_read_value : '0;
    end
  end

  // Peripheral data for an aux read arrives during the ack cycle itself, so it is
  // passed straight through then and held afterwards until the next ack.
  always_comb begin
    resp_live      = (state == RESP) && !reset;
    aux_ack        = resp_live;
    aux_error      = resp_live & err_q;
    aux_read_value = resp_live ? (rd_q ? register_read_value : '0) : read_hold;
    cpu_read_value = last_cpu_read ? register_read_value : '0;
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter with a small read-only peripheral model.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cpu_index;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_write_value, cpu_read_value;
  logic        aux_req, aux_write;
  logic [11:0] aux_index;
  logic [15:0] aux_write_value;
  logic        aux_ack, aux_error;
  logic [15:0] aux_read_value;
  logic [11:0] register_index;
  logic        register_read, register_write;
  logic [15:0] register_write_value, register_read_value;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.AUX_TIMEOUT(16'd4)) dut (
    .clk(clk), .reset(reset),
    .cpu_index(cpu_index), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_write_value(cpu_write_value), .cpu_read_value(cpu_read_value),
    .aux_req(aux_req), .aux_write(aux_write), .aux_index(aux_index),
    .aux_write_value(aux_write_value), .aux_ack(aux_ack), .aux_error(aux_error),
    .aux_read_value(aux_read_value), .register_index(register_index),
    .register_read(register_read), .register_write(register_write),
    .register_write_value(register_write_value), .register_read_value(register_read_value)
  );

  function automatic logic [15:0] peri(input logic [11:0] idx);
    case (idx)
      12'h005: peri = 16'hBEEF;
      12'h010: peri = 16'h1234;
      default: peri = {4'h0, idx};
    endcase
  endfunction

  // Peripheral returns data the cycle after a read strobe.
  always @(posedge clk)
    register_read_value <= register_read ? peri(register_index) : 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_index = '0; cpu_read = 0; cpu_write = 0; cpu_write_value = '0;
    aux_req = 0; aux_write = 0; aux_index = '0; aux_write_value = '0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_ack", aux_ack, 0);
    check("rst_err", aux_error, 0);
    check("rst_arv", aux_read_value, 0);
    check("rst_crv", cpu_read_value, 0);
    check("rst_rd", register_read, 0);
    check("rst_wr", register_write, 0);
    check("rst_idx", register_index, 0);

    // CPU read of 0x005
    cpu_read = 1; cpu_index = 12'h005;
    settle();
    check("cpu_rd_strobe", register_read, 1);
    check("cpu_rd_idx", register_index, 12'h005);
    tick();
    cpu_read = 0;
    settle();
    check("cpu_rd_data", cpu_read_value, 16'hBEEF);
    check("cpu_rd_noack", aux_ack, 0);
    check("cpu_rd_arv", aux_read_value, 0);

    // Aux read on idle bus
    aux_req = 1; aux_write = 0; aux_index = 12'h010;
    settle();
    check("aux_rd_issue", register_read, 1);
    check("aux_rd_idx", register_index, 12'h010);
    check("aux_rd_noack", aux_ack, 0);
    tick();
    settle();
    check("aux_rd_ack", aux_ack, 1);
    check("aux_rd_err", aux_error, 0);
    check("aux_rd_data", aux_read_value, 16'h1234);
    check("aux_rd_noissue", register_read, 0);
    tick();
    aux_req = 0;
    settle();
    check("aux_rd_ackdrop", aux_ack, 0);
    check("aux_rd_hold", aux_read_value, 16'h1234);

    // Aux write blocked by 3 CPU writes; cycle 2 also raises cpu_read
    aux_req = 1; aux_write = 1; aux_index = 12'h020; aux_write_value = 16'hA5A5;
    for (int unsigned i = 0; i < 3; i++) begin
      cpu_write = 1; cpu_read = (i == 1); cpu_index = 12'h030;
      cpu_write_value = 16'h1111 + 16'(i);
      settle();
      check("blk_wv", register_write_value, 16'h1111 + i);
      check("blk_wr", register_write, 1);
      check("blk_rd", register_read, 0);
      check("blk_ack", aux_ack, 0);
      if (i == 2) check("both_strobe_crv", cpu_read_value, 0);
      tick();
    end
    cpu_write = 0; cpu_read = 0;
    settle();
    check("aux_wr_issue", register_write, 1);
    check("aux_wr_rd", register_read, 0);
    check("aux_wr_idx", register_index, 12'h020);
    check("aux_wr_wv", register_write_value, 16'hA5A5);
    tick();
    settle();
    check("aux_wr_ack", aux_ack, 1);
    check("aux_wr_err", aux_error, 0);
    check("aux_wr_arv", aux_read_value, 0);
    tick();
    aux_req = 0;

    // Timeout with continuous CPU reads
    aux_req = 1; aux_write = 1; aux_index = 12'h040; aux_write_value = 16'h7777;
    cpu_read = 1; cpu_index = 12'h005;
    for (int unsigned i = 0; i < 4; i++) begin
      settle();
      check("to_wait_ack", aux_ack, 0);
      check("to_wait_idx", register_index, 12'h005);
      tick();
    end
    settle();
    check("to_ack", aux_ack, 1);
    check("to_err", aux_error, 1);
    check("to_arv", aux_read_value, 0);
    check("to_nowr", register_write, 0);
    check("to_cpu_in_resp", cpu_read_value, 16'hBEEF);
    tick();
    aux_req = 0;
    settle();
    check("to_done", aux_ack, 0);

    // Drop aux_req mid-wait: counter must restart from zero
    aux_req = 1;
    tick(); tick();
    aux_req = 0;
    tick();
    aux_req = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      settle();
      check("drop_wait_ack", aux_ack, 0);
      tick();
    end
    settle();
    check("drop_to_ack", aux_ack, 1);
    check("drop_to_err", aux_error, 1);
    tick();
    aux_req = 0; cpu_read = 0;
    tick();

    // Back-to-back aux reads
    aux_req = 1; aux_write = 0; aux_index = 12'h010;
    settle();
    check("b2b_issue1", register_read, 1);
    tick();
    settle();
    check("b2b_ack1", aux_ack, 1);
    check("b2b_data1", aux_read_value, 16'h1234);
    check("b2b_noissue", register_read, 0);
    tick();
    aux_index = 12'h005;
    settle();
    check("b2b_issue2", register_read, 1);
    check("b2b_gap", aux_ack, 0);
    tick();
    settle();
    check("b2b_ack2", aux_ack, 1);
    check("b2b_data2", aux_read_value, 16'hBEEF);
    tick();

    // Reset during RESP
    aux_index = 12'h010;
    settle();
    check("rr_issue", register_read, 1);
    tick();
    reset = 1; aux_req = 0;
    tick();
    reset = 0;
    settle();
    check("rr_ack", aux_ack, 0);
    check("rr_arv", aux_read_value, 0);
    aux_req = 1;
    settle();
    check("rr_idle_issue", register_read, 1);
    tick();
    settle();
    check("rr_after_ack", aux_ack, 1);
    tick();
    aux_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
